// File: rtl/vga_sync_if.sv
// Timing outputs of the VGA sync generator, consumed by the colour-select stage.
interface vga_sync_if;
    logic       p_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_end;

    modport master (output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_end);
    modport slave  (input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_end);
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 timing generator: pixel-tick divider, h/v counters and registered
// sync/blanking decode aligned with the counters they describe.
module vga_sync_gen #(
    parameter int DIV    = 2,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    vga_sync_if.master  vga
);
    localparam int         H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int         V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam int         DW       = (DIV > 1) ? $clog2(DIV) : 1;

    logic       tick;
    logic [9:0] h_cnt, v_cnt;
    logic [9:0] h_nxt, v_nxt;
    logic       h_wrap;
    logic       video_on_q, hsync_q, vsync_q;

    generate
        if (DIV > 1) begin : g_div
            logic [DW-1:0] div_cnt;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)                      div_cnt <= '0;
                else if (div_cnt == DW'(DIV - 1))  div_cnt <= '0;
                else                               div_cnt <= div_cnt + DW'(1);
            end
            assign tick = (div_cnt == DW'(DIV - 1));
        end else begin : g_nodiv
            assign tick = 1'b1;
        end
    endgenerate

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nxt  = v_cnt;
        if (h_wrap) v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end

    // Decode the next counter values so the registered flags line up with
    // pixel_x/pixel_y on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            video_on_q <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else if (tick) begin
            h_cnt      <= h_nxt;
            v_cnt      <= v_nxt;
            video_on_q <= (h_nxt < H_VIS_L) && (v_nxt < V_VIS_L);
            hsync_q    <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
            vsync_q    <= !((v_nxt >= VS_START) && (v_nxt < VS_END));
        end
    end

    assign vga.p_tick    = tick;
    assign vga.pixel_x   = h_cnt;
    assign vga.pixel_y   = v_cnt;
    assign vga.video_on  = video_on_q;
    assign vga.hsync     = hsync_q;
    assign vga.vsync     = vsync_q;
    assign vga.frame_end = tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
endmodule
